seven_seg_scan_ctrl: RTL and testbench

Time-multiplexes the shared 4-digit seven-segment display. It sequences one digit per 1 kHz enable tick, giving a 250 Hz frame with NUM_DIGITS=4. It also inserts an anti-ghosting blank window on every digit switch, applies leading-zero blanking and per-digit blink, and accepts new display data only at frame boundaries through a load/ack handshake. It sits between the vending FSM (price/credit BCD) and the board pins, and consumes the 1 kHz clock-enable pulse.

---
 rtl/seven_seg_pkg.sv | 20 ++
 rtl/seven_seg_decoder.sv | 18 +
 rtl/seven_seg_scan_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// scan state encoding, blank pattern and the hex-to-segment table.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    // Segments are active-low, bit 0 = segment a.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry n is the pattern for hex digit n (digit F listed first).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern with a
// blank override that forces every segment off.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            seg = HEX_SEG[nibble];
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan of an N-digit seven-segment display with anti-ghost
// blanking, leading-zero suppression, per-digit blink and frame-aligned loads.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_HALF   = 250
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      tick,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      lz_blank,
    input  logic                      load,
    output logic                      load_ack,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BC_W  = $clog2(BLANK_CYCLES + 1);
    localparam int BK_W  = $clog2(BLINK_HALF + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BC_W-1:0]  BLANK_END = BC_W'(BLANK_CYCLES - 1);
    localparam logic [BK_W-1:0]  BLINK_END = BK_W'(BLINK_HALF - 1);

    scan_state_e             state, state_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [BC_W-1:0]         blank_cnt, blank_cnt_nxt;
    logic [BK_W-1:0]         blink_cnt;
    logic                    blink_phase;
    logic                    armed;
    logic                    capture;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_blink;

    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    seen_nonzero;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic                    cur_blink;
    logic                    cur_lz;
    logic                    blink_off;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;

    // Scan sequencing: IDLE until the first tick, then BLANK/SHOW per digit.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        blank_cnt_nxt = blank_cnt;
        capture       = 1'b0;
        wrap          = 1'b0;
        case (state)
            ST_IDLE: begin
                capture = load && armed;
                if (tick) begin
                    state_nxt     = ST_BLANK;
                    idx_nxt       = '0;
                    blank_cnt_nxt = '0;
                end
            end
            ST_BLANK: begin
                if (blank_cnt == BLANK_END) begin
                    state_nxt = ST_SHOW;
                end else begin
                    blank_cnt_nxt = blank_cnt + 1'b1;
                end
            end
            ST_SHOW: begin
                if (tick) begin
                    state_nxt     = ST_BLANK;
                    blank_cnt_nxt = '0;
                    if (idx == LAST_IDX) begin
                        idx_nxt = '0;
                        wrap    = 1'b1;
                        capture = load;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= ST_IDLE;
            idx       <= '0;
            blank_cnt <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            blank_cnt <= blank_cnt_nxt;
        end
    end

    // A held load only captures once in IDLE; it must drop before re-arming.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            armed        <= 1'b1;
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_blink <= '0;
        end else begin
            if (capture) begin
                armed        <= 1'b0;
                shadow_value <= value_in;
                shadow_dp    <= dp_in;
                shadow_blink <= blink_mask;
            end else if (!load) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (tick && state != ST_IDLE) begin
            if (blink_cnt == BLINK_END) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Leading zeros: blank from the top digit down until a nonzero nibble.
    always_comb begin
        lz_mask      = '0;
        seen_nonzero = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (shadow_value[4*i +: 4] != 4'h0) begin
                seen_nonzero = 1'b1;
            end
            lz_mask[i] = lz_blank && !seen_nonzero;
        end
    end

    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blink  = 1'b0;
        cur_lz     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                cur_nibble = shadow_value[4*i +: 4];
                cur_dp     = shadow_dp[i];
                cur_blink  = shadow_blink[i];
                cur_lz     = lz_mask[i];
            end
        end
    end

    assign blink_off = cur_blink && !blink_phase;

    seven_seg_decoder u_decoder (
        .nibble (cur_nibble),
        .blank  (cur_lz || blink_off),
        .seg    (dec_seg)
    );

    // Outputs are registered from the next state so pins line up with state.
    always_comb begin
        an_nxt  = '1;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        if (state_nxt != ST_IDLE) begin
            seg_nxt = dec_seg;
            dp_nxt  = !(cur_dp && !blink_off);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (state_nxt == ST_SHOW && idx_nxt == IDX_W'(i)) begin
                an_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            an         <= '1;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            load_ack   <= capture;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: table of display vectors plus
// hand sequences for scan timing, frame-aligned load, blink and reset.
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int BLANK = 4;
    localparam int BHALF = 3;

    logic          clk;
    logic          clr;
    logic          tick;
    logic [15:0]   value_in;
    logic [3:0]    dp_in;
    logic [3:0]    blink_mask;
    logic          lz_blank;
    logic          load;
    logic          load_ack;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .BLANK_CYCLES (BLANK),
        .BLINK_HALF   (BHALF)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .tick       (tick),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .blink_mask (blink_mask),
        .lz_blank   (lz_blank),
        .load       (load),
        .load_ack   (load_ack),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dpi;
        logic        lz;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
        logic [3:0]  dpo;    // expected dp pin per digit
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
    endtask

    task automatic load_idle(input logic [15:0] v, input string tag);
        value_in = v;
        load     = 1'b1;
        step();
        check({tag, " ack"}, load_ack, 1);
        load = 1'b0;
        step();
        check({tag, " ack drop"}, load_ack, 0);
    endtask

    // Tick, wait out the blank window, then sit in SHOW for the rest of the period.
    task automatic digit_to_show();
        tick_pulse();
        repeat (BLANK) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] exp_seg;
        logic [3:0] exp_an;
        logic [6:0] base [4];
        logic       vis;

        vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[1] = '{16'h0040, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vecs[3] = '{16'h0042, 4'b0100, 1'b0, {7'h40, 7'h40, 7'h19, 7'h24}, 4'b1011};
        vecs[4] = '{16'h0F0E, 4'b1000, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h06}, 4'b0111};
        vecs[5] = '{16'h89AB, 4'b0000, 1'b0, {7'h00, 7'h10, 7'h08, 7'h03}, 4'b1111};
        vecs[6] = '{16'h5C67, 4'b0001, 1'b1, {7'h12, 7'h46, 7'h02, 7'h78}, 4'b1110};
        vecs[7] = '{16'hD000, 4'b0000, 1'b1, {7'h21, 7'h40, 7'h40, 7'h40}, 4'b1111};

        clr = 1'b0; tick = 1'b0; value_in = '0; dp_in = '0;
        blink_mask = '0; lz_blank = 1'b0; load = 1'b0;

        // Reset values and IDLE hold
        do_reset();
        check("rst an", an, 4'hF);
        check("rst seg", seg, 7'h7F);
        check("rst dp", dp, 1);
        check("rst ack", load_ack, 0);
        check("rst frame_done", frame_done, 0);
        repeat (10) step();
        check("idle an", an, 4'hF);
        check("idle seg", seg, 7'h7F);

        // Load in IDLE, first tick and scan timing
        load_idle(16'h1234, "idle load");
        check("idle seg after load", seg, 7'h7F);
        tick_pulse();
        check("t0 an blank", an, 4'hF);
        check("t0 frame_done", frame_done, 0);
        repeat (BLANK - 1) step();
        check("t0 an last blank", an, 4'hF);
        step();
        check("t0 an show", an, 4'b1110);
        check("t0 seg", seg, 7'h19);
        repeat (35) step();
        base[1] = 7'h30; base[2] = 7'h24; base[3] = 7'h79;
        for (int d = 1; d < 4; d++) begin
            tick_pulse();
            check($sformatf("t%0d frame_done", d), frame_done, 0);
            check($sformatf("t%0d ack pending", d), load_ack, 0);
            check($sformatf("t%0d an blank", d), an, 4'hF);
            repeat (BLANK) step();
            exp_an = 4'hF ^ (4'b0001 << d);
            check($sformatf("t%0d an show", d), an, exp_an);
            check($sformatf("t%0d seg old", d), seg, base[d]);
            if (d == 1) begin
                value_in = 16'h0042;
                load     = 1'b1;
            end
            repeat (35) step();
        end
        check("pending ack before wrap", load_ack, 0);
        tick_pulse();
        check("wrap frame_done", frame_done, 1);
        check("wrap ack", load_ack, 1);
        check("wrap an blank", an, 4'hF);
        step();
        check("wrap frame_done drop", frame_done, 0);
        check("held load no reack", load_ack, 0);
        load = 1'b0;
        repeat (BLANK - 1) step();
        check("wrap an show", an, 4'b1110);
        check("new value d0", seg, 7'h24);
        repeat (35) step();
        digit_to_show();
        check("new value d1", seg, 7'h19);
        check("d1 ack idle", load_ack, 0);
        repeat (35) step();

        // Display vectors: decode, leading-zero blanking, dp
        for (int v = 0; v < 8; v++) begin
            do_reset();
            lz_blank = vecs[v].lz;
            dp_in    = vecs[v].dpi;
            load_idle(vecs[v].value, $sformatf("vec%0d", v));
            for (int d = 0; d < 4; d++) begin
                digit_to_show();
                exp_an  = 4'hF ^ (4'b0001 << d);
                exp_seg = vecs[v].segs[7*d +: 7];
                check($sformatf("vec%0d d%0d an", v, d), an, exp_an);
                check($sformatf("vec%0d d%0d seg", v, d), seg, exp_seg);
                check($sformatf("vec%0d d%0d dp", v, d), dp, vecs[v].dpo[d]);
                repeat (35) step();
            end
        end
        lz_blank = 1'b0;
        dp_in    = '0;

        // Blink on digit 0 with dp on digit 2
        do_reset();
        blink_mask = 4'b0001;
        dp_in      = 4'b0100;
        load_idle(16'h1234, "blink load");
        blink_mask = '0;
        dp_in      = '0;
        base[0] = 7'h19; base[1] = 7'h30; base[2] = 7'h24; base[3] = 7'h79;
        for (int k = 0; k < 20; k++) begin
            digit_to_show();
            vis     = ((k / BHALF) % 2) == 0;
            exp_seg = (k % 4 == 0 && !vis) ? 7'h7F : base[k % 4];
            check($sformatf("blink k%0d seg", k), seg, exp_seg);
            check($sformatf("blink k%0d dp", k), dp, (k % 4 == 2) ? 0 : 1);
            repeat (35) step();
        end

        // Asynchronous clear of a pending ack in IDLE
        do_reset();
        value_in = 16'h00FF;
        load     = 1'b1;
        step();
        check("pre-clr ack", load_ack, 1);
        clr = 1'b1;
        #2;
        check("async clr ack", load_ack, 0);
        load = 1'b0;
        step();
        clr = 1'b0;
        step();

        // Clear while showing digit 2
        load_idle(16'h1234, "clr load");
        for (int k = 0; k < 3; k++) begin
            digit_to_show();
            if (k < 2) repeat (35) step();
        end
        check("pre-clr an", an, 4'b1011);
        check("pre-clr seg", seg, 7'h24);
        clr = 1'b1;
        #2;
        check("async clr an", an, 4'hF);
        check("async clr seg", seg, 7'h7F);
        check("async clr dp", dp, 1);
        check("async clr frame_done", frame_done, 0);
        step();
        clr = 1'b0;
        repeat (10) step();
        check("post-clr idle an", an, 4'hF);
        check("post-clr idle seg", seg, 7'h7F);
        digit_to_show();
        check("post-clr restart an", an, 4'b1110);
        check("post-clr shadow cleared", seg, 7'h40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
